// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter sharing one slave port.
// Round-robin between an SPI bridge (m0) and a secondary requester (m1), with
// no preemption and a guaranteed idle bus cycle between ownerships.
// Optional build macro: WB_ARB_TIMEOUT_EN adds a stall watchdog that forces a
// bus error on the granted master after TIMEOUT_CYCLES unanswered strobes.
module wb_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,

  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // prio_m1 = 1 means m1 wins the next simultaneous request (m0 was granted last)
  logic prio_m1;
  logic prio_m1_nxt;

  // Asserted in the cycle the watchdog converts a stalled strobe into an error
  logic timeout_hit;

  // Ownership state and round-robin pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      prio_m1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      prio_m1 <= prio_m1_nxt;
    end
  end

  // Arbitration: decide only from IDLE, hold the owner while its cyc stays high
  always_comb begin
    state_nxt   = state;
    prio_m1_nxt = prio_m1;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (prio_m1) begin
            state_nxt   = GNT1;
            prio_m1_nxt = 1'b0;
          end else begin
            state_nxt   = GNT0;
            prio_m1_nxt = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt   = GNT0;
          prio_m1_nxt = 1'b1;
        end else if (m1_cyc_i) begin
          state_nxt   = GNT1;
          prio_m1_nxt = 1'b0;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) state_nxt = IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus steering: copy the owner onto the slave port and route its response back
  always_comb begin
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    s_sel_o  = 4'd0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_stb_o  = m0_stb_i & ~timeout_hit;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | timeout_hit;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_stb_o  = m1_stb_i & ~timeout_hit;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | timeout_hit;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign o_grant  = {state == GNT1, state == GNT0};

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_cnt;
  logic        granted_req;

  // The owner is actively strobing (before any watchdog masking)
  always_comb begin
    granted_req = 1'b0;
    case (state)
      GNT0:    granted_req = m0_cyc_i & m0_stb_i;
      GNT1:    granted_req = m1_cyc_i & m1_stb_i;
      default: granted_req = 1'b0;
    endcase
  end

  // A real slave response on the limit cycle wins over the forced error
  assign timeout_hit = granted_req && (stall_cnt == TIMEOUT_LIM) && !s_ack_i && !s_err_i;
  assign o_timeout   = timeout_hit;

  // Count unanswered strobe cycles; any response, the forced error or loss of ownership restarts it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= 16'd0;
    end else if (state == IDLE || state_nxt == IDLE || s_ack_i || s_err_i || timeout_hit) begin
      stall_cnt <= 16'd0;
    end else if (granted_req) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign o_timeout          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: randomized scoreboard bench for the two-master arbiter.
// A round-robin reference model predicts grant order; a monitor pops the
// predictions as grants and slave acks appear on the bus.
module tb_wb_arbiter_2m;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0;
  logic        m1_we_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0;
  logic [1:0]  o_grant;
  logic        o_timeout;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i),
    .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
    .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc_n = 0;
  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          start;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  int         slave_mode = 0;
  int         last_gnt = 1;
  logic [1:0] prev_grant = 2'b00;
  int         cur_m = 0;
  int         sl_wcnt = 0;
  int         sl_wtarget = 0;
  bit         sl_nack = 1'b0;
  int         issue = 0;
  int         errs = 0;
  int         tos = 0;
  int         err_cyc = -1;
  logic       stb_at = 1'b1;
  bit         sticky = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic set_slave(input int mode);
    @(negedge i_clk);
    #1;
    slave_mode = mode;
    s_ack_i    = 1'b0;
    s_err_i    = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_grant != g && n < 6);
    checkOutput(name, 32'(o_grant), 32'(g));
  endtask

  // One arbitration round: requesters raise cyc together and each drops it after its ack
  task automatic applyStimulus(input bit r0, input bit r1);
    exp_t e0, e1;
    int   first;
    int   budget;
    bit   done0, done1, see0, see1;
    e0.m = 0; e0.adr = $urandom; e0.dat = $urandom; e0.we = 1'($urandom); e0.sel = 4'($urandom);
    e1.m = 1; e1.adr = $urandom; e1.dat = $urandom; e1.we = 1'($urandom); e1.sel = 4'($urandom);
    @(posedge i_clk);
    #1;
    if (r0) begin
      m0_adr_i = e0.adr; m0_dat_i = e0.dat; m0_we_i = e0.we; m0_sel_i = e0.sel;
      m0_cyc_i = 1'b1;   m0_stb_i = 1'b1;
    end
    if (r1) begin
      m1_adr_i = e1.adr; m1_dat_i = e1.dat; m1_we_i = e1.we; m1_sel_i = e1.sel;
      m1_cyc_i = 1'b1;   m1_stb_i = 1'b1;
    end
    if (r0 && r1) first = (last_gnt == 0) ? 1 : 0;
    else          first = r0 ? 0 : 1;
    e0.start = (first == 0) ? cyc_n : -1;
    e1.start = (first == 1) ? cyc_n : -1;
    if (first == 0) begin
      exp_q.push_back(e0);
      if (r1) exp_q.push_back(e1);
    end else begin
      exp_q.push_back(e1);
      if (r0) exp_q.push_back(e0);
    end
    last_gnt = (r0 && r1) ? 1 - first : first;
    done0 = !r0;
    done1 = !r1;
    budget = 40;
    while (!(done0 && done1) && budget > 0) begin
      @(negedge i_clk);
      see0 = !done0 && (m0_ack_o || m0_err_o);
      see1 = !done1 && (m1_ack_o || m1_err_o);
      @(posedge i_clk);
      #1;
      if (see0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; done0 = 1'b1; end
      if (see1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; done1 = 1'b1; end
      budget--;
    end
    checkOutput("round_done", 32'(done0 && done1), 32'd1);
    if (!(done0 && done1)) begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      exp_q.delete();
    end
    repeat ($urandom_range(0, 2)) @(posedge i_clk);
  endtask

  // Slave model: acks each strobe after a random 0..3 cycle wait when enabled
  initial begin
    forever begin
      @(negedge i_clk);
      sl_nack = 1'b0;
      if (slave_mode == 1) begin
        if (s_cyc_o && s_stb_o && !s_ack_i) begin
          if (sl_wcnt >= sl_wtarget) begin
            sl_nack    = 1'b1;
            sl_wcnt    = 0;
            sl_wtarget = $urandom_range(0, 3);
          end else begin
            sl_wcnt++;
          end
        end else if (!s_cyc_o) begin
          sl_wcnt = 0;
        end
      end
      @(posedge i_clk);
      #1;
      if (slave_mode == 1) begin
        s_ack_i = sl_nack;
        s_dat_i = $urandom;
      end
    end
  end

  // Monitor: pops a prediction on each new grant and checks routing on each slave ack
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        if (o_grant != 2'b00 && o_grant != prev_grant) begin
          if (prev_grant != 2'b00) checkOutput("idle_gap", 32'(prev_grant), 32'd0);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_grant", 32'(o_grant), 32'd0);
          end else begin
            e = exp_q.pop_front();
            cur_m = e.m;
            checkOutput("grant", 32'(o_grant), (e.m == 0) ? 32'd1 : 32'd2);
            checkOutput("s_adr", s_adr_o, e.adr);
            checkOutput("s_dat", s_dat_o, e.dat);
            checkOutput("s_sel", 32'(s_sel_o), 32'(e.sel));
            checkOutput("s_we", 32'(s_we_o), 32'(e.we));
            checkOutput("s_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'd3);
            if (e.start >= 0) checkOutput("latency", 32'(cyc_n), 32'(e.start + 1));
          end
        end
        if (o_grant == 2'b00 && prev_grant != 2'b00) begin
          checkOutput("idle_ctl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
          checkOutput("idle_adr_dat", s_adr_o | s_dat_o, 32'd0);
        end
        if (s_ack_i) begin
          checkOutput("ack_own", 32'((cur_m == 0) ? m0_ack_o : m1_ack_o), 32'd1);
          checkOutput("ack_other", 32'((cur_m == 0) ? m1_ack_o : m0_ack_o), 32'd0);
          checkOutput("rdata", (cur_m == 0) ? m0_dat_o : m1_dat_o, s_dat_i);
          checkOutput("err_quiet", 32'({m0_err_o, m1_err_o, o_timeout}), 32'd0);
        end
      end
      prev_grant = o_grant;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Main sequence: reset, random rounds, then directed edge cases
  initial begin
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s_ack_i = 1'b1;  s_err_i = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_grant", 32'(o_grant), 32'd0);
    checkOutput("rst_bus", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
    checkOutput("rst_resp", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, o_timeout}), 32'd0);
    #1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_ack_i = 1'b0;  s_err_i = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    set_slave(1);
    mon_en = 1'b1;

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 25; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      applyStimulus(r[0], r[1]);
    end
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    set_slave(0);
    @(posedge i_clk);
    #1;
    m1_adr_i = $urandom; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    wait_grant(2'b10, "abort_grant");
    @(posedge i_clk);
    #1;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge i_clk);
    checkOutput("abort_hold", 32'({o_grant, s_cyc_o}), 32'b100);
    @(posedge i_clk);
    #1;
    s_ack_i = 1'b1;
    @(negedge i_clk);
    checkOutput("late_ack", 32'({o_grant, m0_ack_o, m1_ack_o}), 32'd0);
    @(posedge i_clk);
    #1;
    s_ack_i = 1'b0;

    @(posedge i_clk);
    #1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    wait_grant(2'b10, "rst_mid_grant");
    #2;
    i_rst_n = 1'b0;
    s_ack_i = 1'b1;
    #1;
    checkOutput("async_rst", 32'({o_grant, s_cyc_o, m1_ack_o}), 32'd0);
    @(posedge i_clk);
    #1;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n  = 1'b1;
    last_gnt = 1;
    set_slave(1);
    mon_en = 1'b1;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("queue_empty2", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    set_slave(0);
    @(posedge i_clk);
    #1;
    m0_adr_i = 32'h0; m0_dat_i = 32'hF; m0_we_i = 1'b1; m0_sel_i = 4'hF;
    m0_cyc_i = 1'b1;  m0_stb_i = 1'b1;
    issue = cyc_n;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (m0_err_o) begin
        errs++;
        err_cyc = cyc_n;
        stb_at  = s_stb_o;
      end
      if (o_timeout) tos++;
      @(posedge i_clk);
      #1;
      if (errs > 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
    end
    checkOutput("to_err_count", 32'(errs), 32'd1);
    checkOutput("to_pulse_count", 32'(tos), 32'd1);
    checkOutput("to_cycle", 32'(err_cyc), 32'(issue + 5));
    checkOutput("to_stb_forced", 32'(stb_at), 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    issue = cyc_n;
    repeat (5) @(posedge i_clk);
    #1;
    s_ack_i = 1'b1;
    @(negedge i_clk);
    checkOutput("limit_ack", 32'({m0_ack_o, m0_err_o, o_timeout, m1_ack_o}), 32'b1000);
    checkOutput("limit_cycle", 32'(cyc_n), 32'(issue + 5));
    @(posedge i_clk);
    #1;
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge i_clk);
    checkOutput("limit_after", 32'({m0_err_o, o_timeout}), 32'd0);
`else
    sticky = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      if (m0_err_o || o_timeout) sticky = 1'b1;
    end
    checkOutput("no_timeout", 32'(sticky), 32'd0);
    checkOutput("stall_held", 32'({o_grant, s_cyc_o, s_stb_o}), 32'b0111);
    @(posedge i_clk);
    #1;
    s_ack_i = 1'b1;
    @(negedge i_clk);
    checkOutput("stall_ack", 32'({m0_ack_o, m1_ack_o, m0_err_o}), 32'b100);
    @(posedge i_clk);
    #1;
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge i_clk);
`endif
    repeat (2) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
